// File: rtl/dmem_ctrl.sv
// Two-port arbiter/sequencer for a single-port word-wide data memory.
// Handles byte-address to word-index conversion, sub-word loads and RMW sub-word stores.
module dmem_ctrl #(
  parameter int unsigned WIDTH1    = 32,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [WIDTH1-1:0] p0_addr,
  input  logic [1:0]        p0_size,
  input  logic              p0_unsigned,
  input  logic [WIDTH1-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  output logic [WIDTH1-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [WIDTH1-1:0] p1_addr,
  input  logic [1:0]        p1_size,
  input  logic              p1_unsigned,
  input  logic [WIDTH1-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [WIDTH1-1:0] p1_rdata,
  output logic              p1_err,
  output logic [WIDTH1-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_wr,
  output logic [WIDTH1-1:0] mem_wdata,
  input  logic [WIDTH1-1:0] mem_rdata
);

  localparam logic [WIDTH1-3:0] IDX_LIMIT = (WIDTH1-2)'(MEM_WORDS);

  typedef enum logic [2:0] {IDLE, ERR, WR, RD, CAP, RMW_RD, RMW_WR} state_t;

  state_t            state;
  logic              rr_ptr;
  logic              op_port, op_we, op_uns;
  logic [1:0]        op_size;
  logic [WIDTH1-1:0] op_addr, op_wdata;

  logic              grant, sel1, sel_we, sel_uns, sel_bad, fin;
  logic [1:0]        sel_size;
  logic [WIDTH1-1:0] sel_addr, sel_wdata;
  logic [4:0]        lane_sh;
  logic [WIDTH1-1:0] lane_data, lane_mask, load_val, merged;

  // rr_ptr = 0 gives p0 priority when both request.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset && state == IDLE) begin
      if (p0_req && (!p1_req || !rr_ptr)) p0_gnt = 1'b1;
      else if (p1_req)                    p1_gnt = 1'b1;
    end
  end

  assign grant     = p0_gnt | p1_gnt;
  assign sel1      = p1_gnt;
  assign sel_we    = sel1 ? p1_we       : p0_we;
  assign sel_uns   = sel1 ? p1_unsigned : p0_unsigned;
  assign sel_size  = sel1 ? p1_size     : p0_size;
  assign sel_addr  = sel1 ? p1_addr     : p0_addr;
  assign sel_wdata = sel1 ? p1_wdata    : p0_wdata;

  assign sel_bad = (sel_size == 2'b11) ||
                   (sel_size == 2'b01 && sel_addr[0]) ||
                   (sel_size == 2'b10 && sel_addr[1:0] != 2'b00) ||
                   (sel_addr[WIDTH1-1:2] >= IDX_LIMIT);

  // Aligned halves have addr[0]=0, so the byte-lane shift also serves halves.
  assign lane_sh   = {op_addr[1:0], 3'b000};
  assign lane_data = mem_rdata >> lane_sh;

  always_comb begin
    case (op_size)
      2'b00:   load_val = op_uns ? {{(WIDTH1-8){1'b0}}, lane_data[7:0]}
                                 : {{(WIDTH1-8){lane_data[7]}}, lane_data[7:0]};
      2'b01:   load_val = op_uns ? {{(WIDTH1-16){1'b0}}, lane_data[15:0]}
                                 : {{(WIDTH1-16){lane_data[15]}}, lane_data[15:0]};
      default: load_val = lane_data;
    endcase
    lane_mask = ((op_size == 2'b00) ? WIDTH1'(8'hFF) : WIDTH1'(16'hFFFF)) << lane_sh;
    merged    = (mem_rdata & ~lane_mask) | ((op_wdata << lane_sh) & lane_mask);
  end

  // Memory strobes are suppressed during reset so an aborted RMW never writes.
  always_comb begin
    mem_re    = !reset && (state == RD || state == RMW_RD);
    mem_wr    = !reset && (state == WR || state == RMW_WR);
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_re || mem_wr) mem_addr  = {2'b00, op_addr[WIDTH1-1:2]};
    if (mem_wr)           mem_wdata = (state == WR) ? op_wdata : merged;
  end

  assign fin = (state == WR) || (state == CAP) || (state == RMW_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      op_port  <= 1'b0;
      op_we    <= 1'b0;
      op_uns   <= 1'b0;
      op_size  <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      p0_done  <= 1'b0;
      p0_rdata <= '0;
      p0_err   <= 1'b0;
      p1_done  <= 1'b0;
      p1_rdata <= '0;
      p1_err   <= 1'b0;
    end else begin
      p0_done  <= 1'b0;
      p0_rdata <= '0;
      p0_err   <= 1'b0;
      p1_done  <= 1'b0;
      p1_rdata <= '0;
      p1_err   <= 1'b0;

      if (fin) begin
        if (op_port) begin
          p1_done  <= 1'b1;
          p1_rdata <= (state == CAP) ? load_val : '0;
        end else begin
          p0_done  <= 1'b1;
          p0_rdata <= (state == CAP) ? load_val : '0;
        end
      end else if (grant && sel_bad) begin
        if (sel1) begin
          p1_done <= 1'b1;
          p1_err  <= 1'b1;
        end else begin
          p0_done <= 1'b1;
          p0_err  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (grant) begin
            rr_ptr   <= p0_gnt;
            op_port  <= sel1;
            op_we    <= sel_we;
            op_uns   <= sel_uns;
            op_size  <= sel_size;
            op_addr  <= sel_addr;
            op_wdata <= sel_wdata;
            if (sel_bad)                state <= ERR;
            else if (!sel_we)           state <= RD;
            else if (sel_size == 2'b10) state <= WR;
            else                        state <= RMW_RD;
          end
        end
        ERR:     state <= IDLE;
        WR:      state <= IDLE;
        RD:      state <= CAP;
        CAP:     state <= IDLE;
        RMW_RD:  state <= RMW_WR;
        RMW_WR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed scenarios then random single-port traffic,
// checked against an arithmetic model of loads/stores over a shadow word array.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p0_req = 0, p0_we = 0, p0_unsigned = 0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [1:0]  p0_size = '0;
  logic        p0_gnt, p0_done, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 0, p1_we = 0, p1_unsigned = 0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [1:0]  p1_size = '0;
  logic        p1_gnt, p1_done, p1_err;
  logic [31:0] p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_wr;

  logic        bd_we = 1'b0;
  logic [9:0]  bd_idx = '0;
  logic [31:0] bd_data = '0;
  logic [31:0] tmem [0:1023];
  logic [31:0] ref_mem [0:1023];

  int errors = 0;
  int checks = 0;

  dmem_ctrl #(.WIDTH1(32), .MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
    .p0_unsigned(p0_unsigned), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
    .p1_unsigned(p1_unsigned), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read; bd_* is a backdoor preload path.
  always @(posedge clk) begin
    if (bd_we)       tmem[bd_idx] <= bd_data;
    else if (mem_wr) tmem[mem_addr[9:0]] <= mem_wdata;
    if (mem_re) mem_rdata <= tmem[mem_addr[9:0]];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a / 4 >= 1024);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic u);
    longint unsigned v;
    int bits;
    bits = 8 * nbytes(sz);
    v = w;
    v = v >> (8 * (a % 4));
    v = v % (64'd1 << bits);
    if (!u && v >= (64'd1 << (bits - 1))) v = v + (64'd1 << 32) - (64'd1 << bits);
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
    longint unsigned m, r, wv, dv;
    int sh;
    sh = 8 * (a % 4);
    m  = ((64'd1 << (8 * nbytes(sz))) - 1) << sh;
    wv = w;
    dv = d;
    r  = (wv & ~m) | ((dv << sh) & m);
    return r[31:0];
  endfunction

  task automatic drive(input int port, input logic req, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_unsigned = uns; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_unsigned = uns; p1_wdata = wdata;
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    bd_idx = idx[9:0]; bd_data = d; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    drive(0, 0, 0, '0, '0, 0, '0);
    drive(1, 0, 0, '0, '0, 0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ctrl"}, 32'({p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err, mem_re, mem_wr}), 32'h0);
    chk({tag, ".data"}, p0_rdata | p1_rdata | mem_addr | mem_wdata, 32'h0);
  endtask

  task automatic do_op(input int port, input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input string tag);
    logic        e_err;
    int          e_lat, e_re, e_wr;
    logic [31:0] e_rdata, e_wword, e_idx, o_rdata, o_err, a_addr, w_data;
    int          got, t, dk, n_done, n_re, n_wr, stray, other;
    logic        my_done, my_err;
    logic [31:0] my_rdata;
    e_err = model_err(addr, size);
    e_idx = addr >> 2;
    e_rdata = '0; e_wword = '0; e_re = 0; e_wr = 0;
    if (e_err) e_lat = 1;
    else if (!we) begin
      e_lat = 3; e_re = 1;
      e_rdata = model_load(ref_mem[e_idx[9:0]], addr, size, uns);
    end else if (size == 2) begin
      e_lat = 2; e_wr = 1; e_wword = wdata;
    end else begin
      e_lat = 3; e_re = 1; e_wr = 1;
      e_wword = model_store(ref_mem[e_idx[9:0]], addr, size, wdata);
    end

    drive(port, 1, we, addr, size, uns, wdata);
    got = 0; t = 0;
    while (!got && t < 50) begin
      @(negedge clk);
      if ((port == 0) ? p0_gnt : p1_gnt) got = 1;
      else t++;
    end
    chk({tag, ".gnt"}, got, 1);
    if (!got) begin
      drive(port, 0, 0, '0, '0, 0, '0);
      return;
    end
    chk({tag, ".gnt_excl"}, 32'(p0_gnt & p1_gnt), 32'h0);
    @(posedge clk); #1;
    // Scramble the fields after the grant: the controller must use its latched copy.
    drive(port, 0, $urandom_range(0, 1), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom);

    dk = 0; n_done = 0; n_re = 0; n_wr = 0; stray = 0; other = 0;
    o_rdata = '0; o_err = '0; a_addr = '0; w_data = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      my_done  = (port == 0) ? p0_done  : p1_done;
      my_err   = (port == 0) ? p0_err   : p1_err;
      my_rdata = (port == 0) ? p0_rdata : p1_rdata;
      if (mem_re) begin n_re++; a_addr = mem_addr; end
      if (mem_wr) begin n_wr++; a_addr = mem_addr; w_data = mem_wdata; end
      if (mem_re && mem_wr) stray++;
      if (!mem_re && !mem_wr && (mem_addr != 0 || mem_wdata != 0)) stray++;
      if ((port == 0) ? p1_done : p0_done) other++;
      if (my_done) begin
        n_done++;
        if (dk == 0) begin dk = k; o_rdata = my_rdata; o_err = 32'(my_err); end
      end else if (my_rdata != 0 || my_err) stray++;
    end
    chk({tag, ".latency"}, dk, e_lat);
    chk({tag, ".ndone"}, n_done, 1);
    chk({tag, ".err"}, o_err, 32'(e_err));
    chk({tag, ".rdata"}, o_rdata, e_rdata);
    chk({tag, ".mem_re"}, n_re, e_re);
    chk({tag, ".mem_wr"}, n_wr, e_wr);
    chk({tag, ".idle_zero"}, stray, 0);
    chk({tag, ".other_port"}, other, 0);
    if (e_re != 0 || e_wr != 0) chk({tag, ".mem_addr"}, a_addr, e_idx);
    if (e_wr != 0) chk({tag, ".mem_wdata"}, w_data, e_wword);
    if (we && !e_err) ref_mem[e_idx[9:0]] = e_wword;
  endtask

  int seq [4];
  int n, both, d0, d1;
  logic [31:0] ra;

  initial begin
    for (int i = 0; i < 16; i++) poke(i, $urandom);

    // Reset: even with a request pending no output may be active.
    p0_req = 1'b1; p0_size = 2'b10;
    @(negedge clk);
    check_all_zero("reset_hold");
    p0_req = 1'b0;
    reset_dut();
    @(negedge clk);
    check_all_zero("reset_out");

    // Word store then load back.
    do_op(0, 1, 32'h10, 2'b10, 0, 32'hDEADBEEF, "t1_sw");
    do_op(0, 0, 32'h10, 2'b10, 0, 32'h0, "t1_lw");

    // Byte RMW store, signed and unsigned byte loads.
    poke(4, 32'h11223344);
    do_op(0, 1, 32'h13, 2'b00, 0, 32'h000000A5, "t2_sb");
    chk("t2_word", ref_mem[4], 32'hA5223344);
    do_op(0, 0, 32'h13, 2'b00, 0, 32'h0, "t2_lb");
    do_op(1, 0, 32'h13, 2'b00, 1, 32'h0, "t2_lbu");

    // Half loads from both halves.
    poke(8, 32'h80011234);
    do_op(0, 0, 32'h22, 2'b01, 0, 32'h0, "t3_lh");
    do_op(1, 0, 32'h20, 2'b01, 1, 32'h0, "t3_lhu");
    do_op(1, 1, 32'h22, 2'b01, 0, 32'h0000BEEF, "t3_sh");

    // Round-robin with both requests held from reset.
    reset_dut();
    drive(0, 1, 0, 32'h0, 2'b10, 0, '0);
    drive(1, 1, 0, 32'h4, 2'b10, 0, '0);
    n = 0; both = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 4; i++) seq[i] = -1;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (p0_gnt && p1_gnt) both++;
      if (p0_done) d0++;
      if (p1_done) d1++;
      if (p0_gnt) begin seq[n] = 0; n++; end
      else if (p1_gnt) begin seq[n] = 1; n++; end
    end
    @(posedge clk); #1;
    drive(0, 0, 0, '0, '0, 0, '0);
    drive(1, 0, 0, '0, '0, 0, '0);
    repeat (5) begin
      @(negedge clk);
      if (p0_done) d0++;
      if (p1_done) d1++;
    end
    chk("t4_grants", n, 4);
    chk("t4_both", both, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("t4_seq%0d", i), seq[i], i % 2);
    chk("t4_done_p0", d0, 2);
    chk("t4_done_p1", d1, 2);

    // Error cases.
    do_op(0, 1, 32'h11, 2'b01, 0, 32'h1234, "t5_sh_mis");
    do_op(1, 0, 32'h12, 2'b10, 0, 32'h0, "t5_lw_mis");
    do_op(0, 0, 32'h10, 2'b11, 0, 32'h0, "t5_size3");
    do_op(1, 0, 32'h1000, 2'b10, 0, 32'h0, "t5_range");

    // Reset during the write phase of a byte RMW.
    poke(8, 32'hCAFEF00D);
    drive(0, 1, 1, 32'h21, 2'b00, 0, 32'h77);
    n = 0;
    for (int c = 0; c < 20 && n == 0; c++) begin
      @(negedge clk);
      if (p0_gnt) n = 1;
    end
    chk("t6_gnt", n, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, '0, '0, 0, '0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_no_wr", 32'({mem_wr, mem_re}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("t6_after");
    do_op(0, 0, 32'h20, 2'b10, 0, 32'h0, "t6_lw");

    // Random single-port traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) ra = 32'h1000 + $urandom_range(0, 63);
      else ra = 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      do_op($urandom_range(0, 1), $urandom_range(0, 1), ra,
            ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
            $urandom_range(0, 1), $urandom, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
